// File: rtl/soc_boot_loader_if.sv
// Boot-loader bus: load stream, load control/status and instruction fetch port.
// Latency: none (signal bundle only).
// Backpressure: LD_VALID/LD_READY handshake on the load stream; fetch port has none.
//
// Ports (master = loader host + CPU side, slave = soc_boot_loader):
//   LD_START/LD_LEN/LD_SUM : load request, word count and expected checksum
//   LD_DATA/LD_VALID/LD_READY : load word stream
//   FETCH_ADDR/FETCH_DATA  : CPU instruction fetch (1-cycle read latency)
//   CPU_RST/BUSY/DONE/ERR  : processor reset hold and loader status
interface soc_boot_loader_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
);
  logic              LD_START;
  logic [ADDR_W:0]   LD_LEN;
  logic [DATA_W-1:0] LD_SUM;
  logic [DATA_W-1:0] LD_DATA;
  logic              LD_VALID;
  logic              LD_READY;
  logic [ADDR_W-1:0] FETCH_ADDR;
  logic [DATA_W-1:0] FETCH_DATA;
  logic              CPU_RST;
  logic              BUSY;
  logic              DONE;
  logic              ERR;

  modport master (
    output LD_START, LD_LEN, LD_SUM, LD_DATA, LD_VALID, FETCH_ADDR,
    input  LD_READY, FETCH_DATA, CPU_RST, BUSY, DONE, ERR
  );

  modport slave (
    input  LD_START, LD_LEN, LD_SUM, LD_DATA, LD_VALID, FETCH_ADDR,
    output LD_READY, FETCH_DATA, CPU_RST, BUSY, DONE, ERR
  );
endinterface

// File: rtl/soc_boot_loader.sv
// Boot loader: streams an image into instruction RAM, verifies a modular checksum, releases the CPU.
// Latency: one accepted word per cycle while loading; CHECK takes 1 cycle; fetch data 1 cycle after address.
// Backpressure: LD_READY is high only in LOAD; words with LD_VALID low are simply not taken (any gap length).
//
// Ports:
//   CLK  : system clock, all state changes on rising edge
//   RST  : asynchronous active-high reset
//   bus  : soc_boot_loader_if.slave (load stream, status, fetch port); all outputs registered
module soc_boot_loader #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256
) (
  input logic             CLK,
  input logic             RST,
  soc_boot_loader_if.slave bus
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_RUN,
    S_ERROR
  } state_t;

  state_t state_q, state_nxt;

  // Load datapath: word counter doubles as write address; one extra bit
  // so a full-depth load count can be compared against LD_LEN directly.
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W:0]   cnt_inc;
  logic [ADDR_W:0]   len_q;
  logic [DATA_W-1:0] sum_q;
  logic [DATA_W-1:0] exp_sum_q;

  // Registered outputs
  logic              ld_ready_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic              cpu_rst_q;
  logic [DATA_W-1:0] fetch_data_q;

  // Next-state output values
  logic ld_ready_nxt;
  logic busy_nxt;
  logic done_nxt;
  logic err_nxt;
  logic cpu_rst_nxt;

  // Datapath strobes from the FSM
  logic start_go;
  logic accept;
  logic len_ok;

  // Instruction memory: deliberately never reset or cleared, so words beyond
  // the loaded length keep whatever they held before.
  logic [DATA_W-1:0] mem [DEPTH];

  assign cnt_inc = cnt_q + 1'b1;
  assign len_ok  = (bus.LD_LEN != '0) && (bus.LD_LEN <= DEPTH_L);

  // ------------------------------------------------------------------
  // Next-state and next-output logic
  // ------------------------------------------------------------------
  always_comb begin
    state_nxt = state_q;
    start_go  = 1'b0;
    accept    = 1'b0;

    case (state_q)
      S_IDLE, S_RUN, S_ERROR: begin
        if (bus.LD_START) begin
          if (len_ok) begin
            state_nxt = S_LOAD;
            start_go  = 1'b1;
          end else begin
            state_nxt = S_ERROR;
          end
        end
      end

      // LD_START is intentionally not looked at here: a request arriving
      // mid-load must not disturb the image being written.
      S_LOAD: begin
        if (bus.LD_VALID && ld_ready_q) begin
          accept = 1'b1;
          if (cnt_inc == len_q) begin
            state_nxt = S_CHECK;
          end
        end
      end

      // sum_q already includes the last word, accumulated on the edge
      // that left LOAD.
      S_CHECK: begin
        state_nxt = (sum_q == exp_sum_q) ? S_RUN : S_ERROR;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Outputs are decoded from the state being entered and registered, so
    // they change on the same edge as the state (e.g. CPU_RST rises on the
    // edge that leaves RUN for a reload).
    ld_ready_nxt = (state_nxt == S_LOAD);
    busy_nxt     = (state_nxt == S_LOAD) || (state_nxt == S_CHECK);
    done_nxt     = (state_nxt == S_RUN);
    err_nxt      = (state_nxt == S_ERROR);
    cpu_rst_nxt  = (state_nxt != S_RUN);
  end

  // ------------------------------------------------------------------
  // State register
  // ------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // ------------------------------------------------------------------
  // Load datapath: counter, running checksum, latched request
  // ------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q     <= '0;
      len_q     <= '0;
      sum_q     <= '0;
      exp_sum_q <= '0;
    end else if (start_go) begin
      cnt_q     <= '0;
      len_q     <= bus.LD_LEN;
      sum_q     <= '0;
      exp_sum_q <= bus.LD_SUM;
    end else if (accept) begin
      cnt_q <= cnt_inc;
      sum_q <= sum_q + bus.LD_DATA; // wraps modulo 2^DATA_W
    end
  end

  // ------------------------------------------------------------------
  // Status outputs and fetch read port
  // ------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ld_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      cpu_rst_q    <= 1'b1;
      fetch_data_q <= '0;
    end else begin
      ld_ready_q   <= ld_ready_nxt;
      busy_q       <= busy_nxt;
      done_q       <= done_nxt;
      err_q        <= err_nxt;
      cpu_rst_q    <= cpu_rst_nxt;
      // Gated on the entered state so the image is only visible while the
      // CPU is out of reset; the last load word is already in memory when
      // CHECK hands over to RUN.
      fetch_data_q <= (state_nxt == S_RUN) ? mem[bus.FETCH_ADDR] : '0;
    end
  end

  // ------------------------------------------------------------------
  // Instruction memory write port
  // ------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (accept) begin
      mem[cnt_q[ADDR_W-1:0]] <= bus.LD_DATA;
    end
  end

  assign bus.LD_READY   = ld_ready_q;
  assign bus.BUSY       = busy_q;
  assign bus.DONE       = done_q;
  assign bus.ERR        = err_q;
  assign bus.CPU_RST    = cpu_rst_q;
  assign bus.FETCH_DATA = fetch_data_q;

endmodule

// File: tb/tb_soc_boot_loader.sv
// Testbench for soc_boot_loader (DATA_W=16, DEPTH=16): directed and random loads
// against a reference model of the image memory and load outcome.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_soc_boot_loader;
  localparam int DW = 16;
  localparam int DP = 16;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  soc_boot_loader_if #(.DATA_W(DW), .DEPTH(DP)) bus ();

  soc_boot_loader #(.DATA_W(DW), .DEPTH(DP)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: image contents known to the bench, and whether the
  // last load was verified (CPU running).
  logic [DW-1:0] model_mem [DP];
  bit            known     [DP];
  bit            model_run = 1'b0;
  logic [DW-1:0] words [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic r, input logic b,
                         input logic d, input logic e, input logic c);
    chk({tag, ".ready"},   32'(bus.LD_READY), 32'(r));
    chk({tag, ".busy"},    32'(bus.BUSY),     32'(b));
    chk({tag, ".done"},    32'(bus.DONE),     32'(d));
    chk({tag, ".err"},     32'(bus.ERR),      32'(e));
    chk({tag, ".cpu_rst"}, 32'(bus.CPU_RST),  32'(c));
  endtask

  // Outcome of a load is decided purely from the words and expected sum.
  function automatic bit sum_matches(input int len, input logic [DW-1:0] sum);
    int s = 0;
    for (int i = 0; i < len; i++) s += int'(words[i]);
    return (s % 65536) == int'(sum);
  endfunction

  // gap < 0: random 0..3 idle cycles before each word; else fixed gap.
  // spurious: raise LD_START (LD_LEN=1) alongside the first word.
  task automatic do_load(input string tag, input int len, input logic [DW-1:0] sum,
                         input int gap, input bit spurious);
    int g;
    bit pass;
    pass = sum_matches(len, sum);
    @(negedge clk);
    bus.LD_START = 1'b1;
    bus.LD_LEN   = len[AW:0];
    bus.LD_SUM   = sum;
    @(negedge clk);
    bus.LD_START = 1'b0;
    model_run    = 1'b0;
    chk_out({tag, ".load"}, 1, 1, 0, 0, 1);
    chk({tag, ".load_fetch"}, 32'(bus.FETCH_DATA), 32'd0);
    for (int i = 0; i < len; i++) begin
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      bus.LD_VALID = 1'b0;
      for (int k = 0; k < g; k++) begin
        bus.LD_DATA = DW'($urandom);
        @(negedge clk);
      end
      chk({tag, ".ready_before_word"}, 32'(bus.LD_READY), 32'd1);
      bus.LD_VALID = 1'b1;
      bus.LD_DATA  = words[i];
      if (spurious && i == 0) begin
        bus.LD_START = 1'b1;
        bus.LD_LEN   = 5'd1;
        bus.LD_SUM   = words[0];
      end
      @(negedge clk);
      bus.LD_START = 1'b0;
      model_mem[i] = words[i];
      known[i]     = 1'b1;
    end
    bus.LD_VALID = 1'b0;
    chk_out({tag, ".check"}, 0, 1, 0, 0, 1);
    @(negedge clk);
    model_run = pass;
    if (pass) begin
      chk_out({tag, ".run"}, 0, 0, 1, 0, 0);
    end else begin
      chk_out({tag, ".error"}, 0, 0, 0, 1, 1);
      chk({tag, ".error_fetch"}, 32'(bus.FETCH_DATA), 32'd0);
    end
  endtask

  task automatic fetch(input string tag, input int addr);
    bus.FETCH_ADDR = addr[AW-1:0];
    @(negedge clk);
    chk(tag, 32'(bus.FETCH_DATA), model_run ? 32'(model_mem[addr]) : 32'd0);
  endtask

  task automatic bad_start(input string tag, input int len);
    @(negedge clk);
    bus.LD_START = 1'b1;
    bus.LD_LEN   = len[AW:0];
    bus.LD_SUM   = 16'h0000;
    @(negedge clk);
    bus.LD_START = 1'b0;
    model_run    = 1'b0;
    chk_out(tag, 0, 0, 0, 1, 1);
    chk({tag, ".fetch"}, 32'(bus.FETCH_DATA), 32'd0);
  endtask

  initial begin
    int len;
    int a;
    logic [DW-1:0] s;

    bus.LD_START   = 1'b0;
    bus.LD_LEN     = '0;
    bus.LD_SUM     = '0;
    bus.LD_DATA    = '0;
    bus.LD_VALID   = 1'b0;
    bus.FETCH_ADDR = '0;
    for (int i = 0; i < DP; i++) known[i] = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk_out("reset", 0, 0, 0, 0, 1);
    chk("reset.fetch", 32'(bus.FETCH_DATA), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk_out("idle", 0, 0, 0, 0, 1);

    // Nominal load
    words = {16'h0001, 16'h0002, 16'h0003, 16'h0004};
    do_load("nominal", 4, 16'h000A, 0, 1'b0);
    fetch("nominal.fetch2", 2);
    fetch("nominal.fetch0", 0);

    // Bad checksum from RUN (reload: CPU_RST/DONE change on the entering edge)
    do_load("badsum", 4, 16'h000B, 0, 1'b0);
    // Retry with a stray LD_START during LOAD, which must be ignored
    do_load("retry", 4, 16'h000A, 0, 1'b1);
    fetch("retry.fetch3", 3);

    // Backpressure and checksum wrap: exactly two words written
    words = {16'hFFFF, 16'h0002};
    do_load("wrap", 2, 16'h0001, 3, 1'b0);
    for (int i = 0; i < 4; i++) fetch("wrap.fetch", i);

    // Bad lengths
    bad_start("len0", 0);
    bad_start("len17", 17);
    words = {16'h5A5A};
    do_load("after_badlen", 1, 16'h5A5A, 0, 1'b0);
    for (int i = 0; i < 4; i++) fetch("after_badlen.fetch", i);

    // Random loads
    for (int r = 0; r < 6; r++) begin
      len = int'($urandom_range(1, DP));
      words = {};
      s = '0;
      for (int i = 0; i < len; i++) begin
        words.push_back(DW'($urandom));
        s += words[i];
      end
      if ($urandom_range(0, 3) == 0) s = s ^ 16'h0001;
      do_load("random", len, s, -1, 1'b0);
      if (model_run) begin
        for (int k = 0; k < 3; k++) begin
          a = int'($urandom_range(0, DP - 1));
          if (known[a]) fetch("random.fetch", a);
        end
      end
    end

    // Asynchronous reset in the middle of a load
    words = {DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom)};
    @(negedge clk);
    bus.LD_START = 1'b1;
    bus.LD_LEN   = 5'd4;
    bus.LD_SUM   = 16'h1234;
    @(negedge clk);
    bus.LD_START = 1'b0;
    model_run    = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.LD_VALID = 1'b1;
      bus.LD_DATA  = words[i];
      @(negedge clk);
      model_mem[i] = words[i];
      known[i]     = 1'b1;
    end
    bus.LD_VALID = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_out("async_rst", 0, 0, 0, 0, 1);
    chk("async_rst.fetch", 32'(bus.FETCH_DATA), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_out("after_rst", 0, 0, 0, 0, 1);
    s = words[0] + words[1] + words[2] + words[3];
    do_load("after_rst_load", 4, s, -1, 1'b0);
    for (int i = 0; i < 4; i++) fetch("after_rst_load.fetch", i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
